// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble/flush control.
// Optional hazard statistics counters are enabled by defining HAZARD_STATS_EN.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      IF_ID_rs1,
  input  logic [4:0]      IF_ID_rs2,
  input  logic [4:0]      IF_ID_rd,
  input  logic            IF_ID_uses_rs1,
  input  logic            IF_ID_uses_rs2,
  input  logic [XLEN-1:0] IF_ID_pc,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      IF_ID_func3,
  input  logic            ctrl_RegWrite,
  input  logic            ctrl_MemRead,
  input  logic            ctrl_MemWrite,
  input  logic            ctrl_MemtoReg,
  input  logic            ctrl_Branch,
  input  logic            ctrl_ALUSrc,
  input  logic [1:0]      ctrl_ALUOp,
  input  logic            IF_ID_valid,
  input  logic            flush,
  input  logic            ext_stall,
  output logic [4:0]      ID_EX_rs1,
  output logic [4:0]      ID_EX_rs2,
  output logic [4:0]      ID_EX_rd,
  output logic [XLEN-1:0] ID_EX_pc,
  output logic [XLEN-1:0] ID_EX_rd1,
  output logic [XLEN-1:0] ID_EX_rd2,
  output logic [XLEN-1:0] ID_EX_imm,
  output logic [2:0]      ID_EX_func3,
  output logic            ID_EX_RegWrite,
  output logic            ID_EX_MemRead,
  output logic            ID_EX_MemWrite,
  output logic            ID_EX_MemtoReg,
  output logic            ID_EX_Branch,
  output logic            ID_EX_ALUSrc,
  output logic [1:0]      ID_EX_ALUOp,
  output logic            ID_EX_valid,
  output logic            PCWrite,
  output logic            IF_ID_Write,
  output logic            load_use_stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]     stall_count,
  output logic [31:0]     bubble_count
`endif
);

  // Control bits packed as {RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp[1:0]}
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0] pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [2:0]      func3_q, func3_d;
  logic [7:0]      ctrl_q, ctrl_d;
  logic            valid_q, valid_d;
  logic            hz_s, bubble_s, kill_ctrl_s;

  always_comb begin
    hz_s = valid_q & ctrl_q[6] & (rd_q != 5'd0) &
           ((IF_ID_uses_rs1 & (rd_q == IF_ID_rs1)) | (IF_ID_uses_rs2 & (rd_q == IF_ID_rs2)));
    load_use_stall = hz_s & ~flush & ~ext_stall;
    PCWrite        = ~(load_use_stall | ext_stall);
    IF_ID_Write    = ~(load_use_stall | ext_stall);
    bubble_s       = flush | load_use_stall;
    kill_ctrl_s    = bubble_s | ~IF_ID_valid;
  end

  // Next-state: datapath always follows ID; rd and control are squashed for bubbles.
  always_comb begin
    rs1_d   = IF_ID_rs1;
    rs2_d   = IF_ID_rs2;
    pc_d    = IF_ID_pc;
    rd1_d   = rd1;
    rd2_d   = rd2;
    imm_d   = imm;
    func3_d = IF_ID_func3;
    rd_d    = bubble_s ? 5'd0 : IF_ID_rd;
    ctrl_d  = kill_ctrl_s ? 8'd0 :
              {ctrl_RegWrite, ctrl_MemRead, ctrl_MemWrite, ctrl_MemtoReg,
               ctrl_Branch, ctrl_ALUSrc, ctrl_ALUOp};
    valid_d = bubble_s ? 1'b0 : IF_ID_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      rd_q    <= 5'd0;
      pc_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      func3_q <= 3'd0;
      ctrl_q  <= 8'd0;
      valid_q <= 1'b0;
    end else if (!ext_stall) begin
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      pc_q    <= pc_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      func3_q <= func3_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign ID_EX_rs1      = rs1_q;
  assign ID_EX_rs2      = rs2_q;
  assign ID_EX_rd       = rd_q;
  assign ID_EX_pc       = pc_q;
  assign ID_EX_rd1      = rd1_q;
  assign ID_EX_rd2      = rd2_q;
  assign ID_EX_imm      = imm_q;
  assign ID_EX_func3    = func3_q;
  assign ID_EX_RegWrite = ctrl_q[7];
  assign ID_EX_MemRead  = ctrl_q[6];
  assign ID_EX_MemWrite = ctrl_q[5];
  assign ID_EX_MemtoReg = ctrl_q[4];
  assign ID_EX_Branch   = ctrl_q[3];
  assign ID_EX_ALUSrc   = ctrl_q[2];
  assign ID_EX_ALUOp    = ctrl_q[1:0];
  assign ID_EX_valid    = valid_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  // Saturating statistics, frozen together with the stage during ext_stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else if (!ext_stall) begin
      if (load_use_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (bubble_s && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end else begin
        bubble_cnt_q <= bubble_cnt_q;
      end
    end else begin
      stall_cnt_q  <= stall_cnt_q;
      bubble_cnt_q <= bubble_cnt_q;
    end
  end

  assign stall_count  = stall_cnt_q;
  assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; counter checks compile in with HAZARD_STATS_EN.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  IF_ID_rs1, IF_ID_rs2, IF_ID_rd;
  logic        IF_ID_uses_rs1, IF_ID_uses_rs2;
  logic [31:0] IF_ID_pc, rd1, rd2, imm;
  logic [2:0]  IF_ID_func3;
  logic        ctrl_RegWrite, ctrl_MemRead, ctrl_MemWrite, ctrl_MemtoReg, ctrl_Branch, ctrl_ALUSrc;
  logic [1:0]  ctrl_ALUOp;
  logic        IF_ID_valid, flush, ext_stall;
  logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic [31:0] ID_EX_pc, ID_EX_rd1, ID_EX_rd2, ID_EX_imm;
  logic [2:0]  ID_EX_func3;
  logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_Branch, ID_EX_ALUSrc;
  logic [1:0]  ID_EX_ALUOp;
  logic        ID_EX_valid, PCWrite, IF_ID_Write, load_use_stall;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count, bubble_count;
  logic [31:0] sc0, bc0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // {RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc}
  localparam logic [5:0] C_LW  = 6'b110101;
  localparam logic [5:0] C_ADD = 6'b100000;
  localparam logic [5:0] C_SW  = 6'b001001;
  localparam logic [5:0] C_LUI = 6'b100001;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .IF_ID_rd(IF_ID_rd),
    .IF_ID_uses_rs1(IF_ID_uses_rs1), .IF_ID_uses_rs2(IF_ID_uses_rs2),
    .IF_ID_pc(IF_ID_pc), .rd1(rd1), .rd2(rd2), .imm(imm), .IF_ID_func3(IF_ID_func3),
    .ctrl_RegWrite(ctrl_RegWrite), .ctrl_MemRead(ctrl_MemRead), .ctrl_MemWrite(ctrl_MemWrite),
    .ctrl_MemtoReg(ctrl_MemtoReg), .ctrl_Branch(ctrl_Branch), .ctrl_ALUSrc(ctrl_ALUSrc),
    .ctrl_ALUOp(ctrl_ALUOp), .IF_ID_valid(IF_ID_valid), .flush(flush), .ext_stall(ext_stall),
    .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_pc(ID_EX_pc), .ID_EX_rd1(ID_EX_rd1), .ID_EX_rd2(ID_EX_rd2), .ID_EX_imm(ID_EX_imm),
    .ID_EX_func3(ID_EX_func3), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg), .ID_EX_Branch(ID_EX_Branch),
    .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp), .ID_EX_valid(ID_EX_valid),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .load_use_stall(load_use_stall)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count), .bubble_count(bubble_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in ID; datapath values derive from dat.
  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                       input logic u1, input logic u2, input logic [5:0] c, input logic [1:0] op,
                       input logic [31:0] dat);
    IF_ID_valid = v; IF_ID_rs1 = r1; IF_ID_rs2 = r2; IF_ID_rd = d;
    IF_ID_uses_rs1 = u1; IF_ID_uses_rs2 = u2;
    {ctrl_RegWrite, ctrl_MemRead, ctrl_MemWrite, ctrl_MemtoReg, ctrl_Branch, ctrl_ALUSrc} = c;
    ctrl_ALUOp = op;
    IF_ID_pc = dat; rd1 = dat ^ 32'hA5A5_A5A5; rd2 = dat + 32'd1; imm = dat + 32'd2;
    IF_ID_func3 = dat[2:0];
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0, 2'd0, 32'd0);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; ext_stall = 1'b0;
    drive(1'b1, 5'd2, 5'd3, 5'd5, 1'b1, 1'b0, C_LW, 2'd0, 32'h0000_0040);
    tick(); tick();
    n_vec++; if (ID_EX_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", ID_EX_valid); end
    n_vec++; if (ID_EX_rd !== 5'd0) begin n_err++; $display("FAIL rst_rd got=%0d exp=0", ID_EX_rd); end
    n_vec++; if (ID_EX_MemRead !== 1'b0) begin n_err++; $display("FAIL rst_memread got=%b exp=0", ID_EX_MemRead); end
    n_vec++; if (ID_EX_pc !== 32'd0) begin n_err++; $display("FAIL rst_pc got=%h exp=0", ID_EX_pc); end
    n_vec++; if (PCWrite !== 1'b1 || IF_ID_Write !== 1'b1) begin n_err++; $display("FAIL rst_pcwrite got=%b%b exp=11", PCWrite, IF_ID_Write); end
`ifdef HAZARD_STATS_EN
    n_vec++; if (stall_count !== 32'd0 || bubble_count !== 32'd0) begin n_err++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", stall_count, bubble_count); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    nop();
    drive(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 2'd0, 32'h0000_0100);
    tick();
    drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, C_ADD, 2'b10, 32'h0000_1004);
`ifdef HAZARD_STATS_EN
    sc0 = stall_count; bc0 = bubble_count;
`endif
    n_vec++; if (load_use_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got=%b exp=1", load_use_stall); end
    n_vec++; if (PCWrite !== 1'b0 || IF_ID_Write !== 1'b0) begin n_err++; $display("FAIL lu_pcwrite got=%b%b exp=00", PCWrite, IF_ID_Write); end
    tick();
    n_vec++; if (ID_EX_valid !== 1'b0 || ID_EX_rd !== 5'd0) begin n_err++; $display("FAIL lu_bubble got=v%b rd%0d exp=v0 rd0", ID_EX_valid, ID_EX_rd); end
    n_vec++; if (ID_EX_RegWrite !== 1'b0 || ID_EX_MemRead !== 1'b0) begin n_err++; $display("FAIL lu_bubble_ctrl got=%b%b exp=00", ID_EX_RegWrite, ID_EX_MemRead); end
    n_vec++; if (load_use_stall !== 1'b0 || PCWrite !== 1'b1) begin n_err++; $display("FAIL lu_one_bubble got=%b%b exp=01", load_use_stall, PCWrite); end
`ifdef HAZARD_STATS_EN
    n_vec++; if (stall_count !== sc0 + 32'd1 || bubble_count !== bc0 + 32'd1) begin n_err++; $display("FAIL lu_cnt got=%0d/%0d exp=%0d/%0d", stall_count, bubble_count, sc0 + 32'd1, bc0 + 32'd1); end
`endif
    tick();
    n_vec++; if (ID_EX_rs1 !== 5'd5 || ID_EX_rd !== 5'd6 || ID_EX_valid !== 1'b1) begin n_err++; $display("FAIL lu_add got=rs1 %0d rd %0d v%b exp=5 6 1", ID_EX_rs1, ID_EX_rd, ID_EX_valid); end
    n_vec++; if (ID_EX_RegWrite !== 1'b1 || ID_EX_ALUOp !== 2'b10 || ID_EX_MemRead !== 1'b0) begin n_err++; $display("FAIL lu_add_ctrl got=%b %b %b exp=1 10 0", ID_EX_RegWrite, ID_EX_ALUOp, ID_EX_MemRead); end
    n_vec++; if (ID_EX_rd1 !== 32'hA5A5_B5A1 || ID_EX_imm !== 32'h0000_1006) begin n_err++; $display("FAIL lu_add_data got=%h %h exp=a5a5b5a1 00001006", ID_EX_rd1, ID_EX_imm); end
    n_vec++; if (ID_EX_pc !== 32'h0000_1004 || ID_EX_func3 !== 3'b100 || ID_EX_rd2 !== 32'h0000_1005) begin n_err++; $display("FAIL lu_add_pc got=%h %b %h exp=00001004 100 00001005", ID_EX_pc, ID_EX_func3, ID_EX_rd2); end
  endtask

  task automatic test_no_stall();
    nop();
    drive(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, C_LW, 2'd0, 32'h0000_0200);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, C_ADD, 2'b10, 32'h0000_0204);
    n_vec++; if (load_use_stall !== 1'b0 || PCWrite !== 1'b1) begin n_err++; $display("FAIL ns_x0 got=%b%b exp=01", load_use_stall, PCWrite); end
    tick();
    drive(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 2'd0, 32'h0000_0208);
    tick();
    drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, C_LUI, 2'd0, 32'h0000_020C);
    n_vec++; if (load_use_stall !== 1'b0 || PCWrite !== 1'b1) begin n_err++; $display("FAIL ns_lui got=%b%b exp=01", load_use_stall, PCWrite); end
    tick();
    n_vec++; if (ID_EX_valid !== 1'b1 || ID_EX_rd !== 5'd5 || ID_EX_ALUSrc !== 1'b1) begin n_err++; $display("FAIL ns_lui_load got=v%b rd%0d a%b exp=v1 rd5 a1", ID_EX_valid, ID_EX_rd, ID_EX_ALUSrc); end
    drive(1'b0, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 2'd0, 32'h0000_0210);
    tick();
    n_vec++; if (ID_EX_MemRead !== 1'b0 || ID_EX_valid !== 1'b0) begin n_err++; $display("FAIL ns_invalid_ctrl got=%b%b exp=00", ID_EX_MemRead, ID_EX_valid); end
    drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, C_ADD, 2'b10, 32'h0000_0214);
    n_vec++; if (load_use_stall !== 1'b0) begin n_err++; $display("FAIL ns_after_invalid got=%b exp=0", load_use_stall); end
  endtask

  task automatic test_store();
    nop();
    drive(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 2'd0, 32'h0000_0300);
    tick();
    drive(1'b1, 5'd2, 5'd5, 5'd0, 1'b1, 1'b1, C_SW, 2'd0, 32'h0000_0304);
    n_vec++; if (load_use_stall !== 1'b1) begin n_err++; $display("FAIL sw_stall got=%b exp=1", load_use_stall); end
    tick();
    n_vec++; if (ID_EX_valid !== 1'b0 || ID_EX_MemWrite !== 1'b0 || load_use_stall !== 1'b0) begin n_err++; $display("FAIL sw_bubble got=%b%b%b exp=000", ID_EX_valid, ID_EX_MemWrite, load_use_stall); end
    tick();
    n_vec++; if (ID_EX_valid !== 1'b1 || ID_EX_MemWrite !== 1'b1 || ID_EX_rs2 !== 5'd5) begin n_err++; $display("FAIL sw_load got=v%b w%b rs2 %0d exp=v1 w1 5", ID_EX_valid, ID_EX_MemWrite, ID_EX_rs2); end
  endtask

  task automatic test_flush();
    nop();
    drive(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 2'd0, 32'h0000_0400);
    tick();
    drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, C_ADD, 2'b10, 32'h0000_0404);
    flush = 1'b1; #1;
`ifdef HAZARD_STATS_EN
    sc0 = stall_count; bc0 = bubble_count;
`endif
    n_vec++; if (load_use_stall !== 1'b0 || PCWrite !== 1'b1) begin n_err++; $display("FAIL fl_hz got=%b%b exp=01", load_use_stall, PCWrite); end
    tick();
    flush = 1'b0;
    n_vec++; if (ID_EX_valid !== 1'b0 || ID_EX_rd !== 5'd0 || ID_EX_RegWrite !== 1'b0) begin n_err++; $display("FAIL fl_bubble got=v%b rd%0d w%b exp=v0 rd0 w0", ID_EX_valid, ID_EX_rd, ID_EX_RegWrite); end
`ifdef HAZARD_STATS_EN
    n_vec++; if (stall_count !== sc0 || bubble_count !== bc0 + 32'd1) begin n_err++; $display("FAIL fl_cnt got=%0d/%0d exp=%0d/%0d", stall_count, bubble_count, sc0, bc0 + 32'd1); end
`endif
  endtask

  task automatic test_ext_stall();
    nop();
    drive(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b1, C_ADD, 2'b10, 32'h0000_2000);
    tick();
    drive(1'b1, 5'd1, 5'd1, 5'd9, 1'b1, 1'b1, C_ADD, 2'b10, 32'h0000_3000);
    ext_stall = 1'b1; flush = 1'b1; #1;
`ifdef HAZARD_STATS_EN
    sc0 = stall_count; bc0 = bubble_count;
`endif
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (PCWrite !== 1'b0 || IF_ID_Write !== 1'b0) begin n_err++; $display("FAIL es_pcwrite[%0d] got=%b%b exp=00", i, PCWrite, IF_ID_Write); end
      tick();
      n_vec++; if (ID_EX_rd !== 5'd6 || ID_EX_valid !== 1'b1 || ID_EX_rd1 !== 32'hA5A5_85A5) begin n_err++; $display("FAIL es_hold[%0d] got=rd%0d v%b %h exp=rd6 v1 a5a585a5", i, ID_EX_rd, ID_EX_valid, ID_EX_rd1); end
    end
`ifdef HAZARD_STATS_EN
    n_vec++; if (bubble_count !== bc0 || stall_count !== sc0) begin n_err++; $display("FAIL es_cnt got=%0d/%0d exp=%0d/%0d", stall_count, bubble_count, sc0, bc0); end
`endif
    ext_stall = 1'b0; flush = 1'b0; #1;
    n_vec++; if (PCWrite !== 1'b1) begin n_err++; $display("FAIL es_resume_pc got=%b exp=1", PCWrite); end
    tick();
    n_vec++; if (ID_EX_rd !== 5'd9 || ID_EX_pc !== 32'h0000_3000 || ID_EX_valid !== 1'b1) begin n_err++; $display("FAIL es_resume got=rd%0d %h v%b exp=rd9 00003000 v1", ID_EX_rd, ID_EX_pc, ID_EX_valid); end
    drive(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 2'd0, 32'h0000_3100);
    tick();
    drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, C_ADD, 2'b10, 32'h0000_3104);
    ext_stall = 1'b1; #1;
    n_vec++; if (load_use_stall !== 1'b0 || PCWrite !== 1'b0) begin n_err++; $display("FAIL es_hz got=%b%b exp=00", load_use_stall, PCWrite); end
    ext_stall = 1'b0; #1;
    n_vec++; if (load_use_stall !== 1'b1) begin n_err++; $display("FAIL es_hz_release got=%b exp=1", load_use_stall); end
  endtask

  task automatic test_reset_mid_stall();
    nop();
    drive(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 2'd0, 32'h0000_0500);
    tick();
    drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, C_ADD, 2'b10, 32'h0000_0504);
    n_vec++; if (load_use_stall !== 1'b1) begin n_err++; $display("FAIL rm_pre got=%b exp=1", load_use_stall); end
    rst_n = 1'b0;
    tick();
    n_vec++; if (ID_EX_valid !== 1'b0 || ID_EX_MemRead !== 1'b0 || ID_EX_rd !== 5'd0 || ID_EX_rd1 !== 32'd0 || ID_EX_rs1 !== 5'd0) begin n_err++; $display("FAIL rm_clear got=v%b m%b rd%0d %h rs1 %0d exp=all 0", ID_EX_valid, ID_EX_MemRead, ID_EX_rd, ID_EX_rd1, ID_EX_rs1); end
`ifdef HAZARD_STATS_EN
    n_vec++; if (stall_count !== 32'd0 || bubble_count !== 32'd0) begin n_err++; $display("FAIL rm_cnt got=%0d/%0d exp=0/0", stall_count, bubble_count); end
`endif
    rst_n = 1'b1; #1;
    n_vec++; if (load_use_stall !== 1'b0 || PCWrite !== 1'b1 || IF_ID_Write !== 1'b1) begin n_err++; $display("FAIL rm_after got=%b%b%b exp=011", load_use_stall, PCWrite, IF_ID_Write); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ext_stall = 1'b0;
    test_reset();
    test_load_use();
    test_no_stall();
    test_store();
    test_flush();
    test_ext_stall();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the five-stage RV32I core, with integrated load-use hazard detection and bubble/flush control. It captures decoded operands and control from the ID stage each cycle. It drives the EX stage, including the ID_EX_rs1/ID_EX_rs2/ID_EX_rd/ID_EX_RegWrite fields consumed by the forwarding unit. It also generates the PC/IF_ID write enables that stall the front end on a load-use dependency.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- IF_ID_rs1, IF_ID_rs2, IF_ID_rd  in  5 each  register specifiers of the instruction in ID
- IF_ID_uses_rs1, IF_ID_uses_rs2  in  1 each  instruction actually reads that source
- IF_ID_pc, rd1, rd2, imm  in  XLEN each  PC, register-file read data, immediate
- IF_ID_func3  in  3  funct3
- ctrl_RegWrite, ctrl_MemRead, ctrl_MemWrite, ctrl_MemtoReg, ctrl_Branch, ctrl_ALUSrc  in  1 each  decoder control
- ctrl_ALUOp  in  2  ALU op class
- IF_ID_valid  in  1  ID holds a real instruction
- flush  in  1  taken branch/jump resolved downstream; kill ID instruction
- ext_stall  in  1  downstream (memory) stall; freeze this stage
- ID_EX_* outputs  out  registered copies of every input field above: rs1, rs2, rd, pc, rd1, rd2, imm, func3, all ctrl_* bits, and valid
- PCWrite  out  1  PC may advance
- IF_ID_Write  out  1  IF/ID register may load
- load_use_stall  out  1  bubble being inserted this cycle
- stall_count, bubble_count  out  32 each  present only with HAZARD_STATS_EN

## Operation
- Load-use detect (combinational): hz = ID_EX_valid & ID_EX_MemRead & (ID_EX_rd != 0) & ((IF_ID_uses_rs1 & ID_EX_rd == IF_ID_rs1) | (IF_ID_uses_rs2 & ID_EX_rd == IF_ID_rs2)).
- load_use_stall = hz & !flush & !ext_stall.
- PCWrite = IF_ID_Write = !(load_use_stall | ext_stall).
- Register update priority at each rising edge:
  - !rst_n: all ID_EX_* cleared to 0 (valid 0, ctrl 0).
  - ext_stall: all ID_EX_* hold their values.
  - flush: bubble is loaded.
  - load_use_stall: bubble is loaded.
  - Otherwise: every ID_EX_* field loads its input, and ID_EX_valid <= IF_ID_valid.
- Bubble: ID_EX_valid, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_Branch all 0. ID_EX_rd is forced to 0 so no forwarding match can occur. Datapath fields are don't-care and are loaded from inputs.
- Invalid input (IF_ID_valid=0) is loaded with all ctrl bits forced to 0.
- Never more than one consecutive load-use bubble per load. After the bubble, ID_EX_MemRead=0, so hz deasserts. The dependency is then resolved by MEM/WB forwarding.

## Timing
- Register latency 1 cycle: ID inputs at edge N are visible on ID_EX_* after edge N.
- hz, load_use_stall, PCWrite and IF_ID_Write are combinational from current ID_EX_* state and ID inputs. They have no registered delay, and there is no combinational path from flush or ext_stall to the ID_EX_* outputs.
- Reset values: all ID_EX_* 0. Out of reset, ID_EX_* = 0, so PCWrite=1, IF_ID_Write=1 and load_use_stall=0. Counters are 0.
- Reset asserted mid-stall clears state on that edge. The following cycle shows no stall regardless of ID inputs.
- flush and hz together: flush wins, load_use_stall=0, PCWrite=1. The PC loads the branch target.
- ext_stall with flush: ext_stall wins. The flush source must hold flush until ext_stall drops.

## Configuration
- HAZARD_STATS_EN defined: stall_count increments every cycle load_use_stall=1. bubble_count increments every edge a bubble is loaded, whether from flush or load-use.
  - Both counters are 32-bit saturating at 0xFFFFFFFF, cleared by reset, and frozen during ext_stall.
- Undefined: the ports and counters do not exist, and the rest of the behaviour is identical.

## Test plan
- lw x5 in EX, add x6,x5,x7 in ID (uses_rs1=1) -> load_use_stall=1 and PCWrite=0 for exactly one cycle. Next cycle ID_EX_valid=0 and ID_EX_rd=0; the cycle after, the add appears with ID_EX_rs1=5.
- lw x0 in EX, add using x0 -> no stall. Also lui x5 (uses_rs1=uses_rs2=0) behind lw x5 -> no stall.
- lw x5 in EX plus sw x5 in ID (uses_rs2=1, rs2=5) -> one bubble.
- hz and flush asserted in the same cycle -> load_use_stall=0, PCWrite=1, bubble loaded, bubble_count +1 and stall_count unchanged (HAZARD_STATS_EN).
- ext_stall held 3 cycles with a valid add in EX -> ID_EX_* unchanged for 3 edges, PCWrite=0, then the pipeline resumes normally.
- rst_n=0 for one cycle during a load-use stall -> all ID_EX_* 0, counters 0, PCWrite=1 the next cycle.
